// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: 2-flop sync, per-channel debounce, quarter-step
// decode into a detent counter. Define QUAD_ENCODER_SATURATE_EN to clamp value instead of wrapping.
module quad_encoder_counter #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enc_a,
   input  logic             enc_b,
   output logic [WIDTH-1:0] value,
   output logic             inc,
   output logic             dec,
   output logic             err
);

   localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [1:0]      sync_a;
   logic [1:0]      sync_b;
   logic [1:0]      synced;
   logic [1:0]      filt;
   logic [1:0][7:0] db_cnt;
   logic [1:0]      prev;
   logic            primed;
   logic signed [3:0] acc;
   logic signed [3:0] acc_step;
   logic            step_cw;
   logic            step_ccw;
   logic            step_both;
   logic [WIDTH-1:0] val_up;
   logic [WIDTH-1:0] val_dn;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {sync_a[0], enc_a};
         sync_b <= {sync_b[0], enc_b};
      end
   end

   assign synced = {sync_a[1], sync_b[1]};

   // Bit 1 is channel A, bit 0 is channel B, matching the {A,B} state encoding.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt   <= '0;
         db_cnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (synced[i] != filt[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  filt[i]   <= synced[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 8'd1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   always_comb begin
      step_cw   = 1'b0;
      step_ccw  = 1'b0;
      step_both = 1'b0;
      case ({prev, filt})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_cw   = 1'b1;
         4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: step_ccw  = 1'b1;
         4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: step_both = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      acc_step = acc;
      if (step_cw)
         acc_step = acc + 4'sd1;
      else if (step_ccw)
         acc_step = acc - 4'sd1;
   end

`ifdef QUAD_ENCODER_SATURATE_EN
   assign val_up = (value == {WIDTH{1'b1}}) ? value : value + WIDTH'(1);
   assign val_dn = (value == '0) ? value : value - WIDTH'(1);
`else
   assign val_up = value + WIDTH'(1);
   assign val_dn = value - WIDTH'(1);
`endif

   // First filtered change after reset only establishes the reference state.
   always_ff @(posedge clk) begin
      if (reset) begin
         value  <= '0;
         inc    <= 1'b0;
         dec    <= 1'b0;
         err    <= 1'b0;
         acc    <= '0;
         prev   <= '0;
         primed <= 1'b0;
      end else begin
         inc <= 1'b0;
         dec <= 1'b0;
         err <= 1'b0;
         if (filt != prev) begin
            prev <= filt;
            if (!primed) begin
               primed <= 1'b1;
            end else if (step_both) begin
               err <= 1'b1;
            end else if (acc_step == 4'sd4) begin
               acc   <= '0;
               inc   <= 1'b1;
               value <= val_up;
            end else if (acc_step == -4'sd4) begin
               acc   <= '0;
               dec   <= 1'b1;
               value <= val_dn;
            end else begin
               acc <= acc_step;
            end
         end
      end
   end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench for quad_encoder_counter (WIDTH=8, DEBOUNCE_CYCLES=4); expected
// values follow QUAD_ENCODER_SATURATE_EN when it is defined for the build.
module tb_quad_encoder_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       enc_a;
   logic       enc_b;
   logic [7:0] value;
   logic       inc;
   logic       dec;
   logic       err;

   int total = 0;
   int bad   = 0;
   int n_inc = 0, n_dec = 0, n_err = 0, n_overlap = 0, n_wide = 0;
   int e_inc = 0, e_dec = 0, e_err = 0, e_val = 0;
   logic p_inc = 1'b0, p_dec = 1'b0, p_err = 1'b0;

   quad_encoder_counter #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .enc_a (enc_a),
      .enc_b (enc_b),
      .value (value),
      .inc   (inc),
      .dec   (dec),
      .err   (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (inc) n_inc++;
      if (dec) n_dec++;
      if (err) n_err++;
      if ((int'(inc) + int'(dec) + int'(err)) > 1) n_overlap++;
      if ((inc && p_inc) || (dec && p_dec) || (err && p_err)) n_wide++;
      p_inc = inc;
      p_dec = dec;
      p_err = err;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_ab(input logic a, input logic b, input int hold);
      enc_a = a;
      enc_b = b;
      repeat (hold) @(negedge clk);
   endtask

   task automatic cw_detent(input int hold);
      set_ab(1'b1, 1'b0, hold);
      set_ab(1'b1, 1'b1, hold);
      set_ab(1'b0, 1'b1, hold);
      set_ab(1'b0, 1'b0, hold);
   endtask

   task automatic ccw_detent(input int hold);
      set_ab(1'b0, 1'b1, hold);
      set_ab(1'b1, 1'b1, hold);
      set_ab(1'b1, 1'b0, hold);
      set_ab(1'b0, 1'b0, hold);
   endtask

   function automatic int up(input int v);
`ifdef QUAD_ENCODER_SATURATE_EN
      return (v == 255) ? 255 : v + 1;
`else
      return (v + 1) & 255;
`endif
   endfunction

   function automatic int dn(input int v);
`ifdef QUAD_ENCODER_SATURATE_EN
      return (v == 0) ? 0 : v - 1;
`else
      return (v + 255) & 255;
`endif
   endfunction

   initial begin
      reset = 1'b1;
      enc_a = 1'b0;
      enc_b = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_value", int'(value), 0);
      chk("reset_inc", int'(inc), 0);
      chk("reset_dec", int'(dec), 0);
      chk("reset_err", int'(err), 0);

      // Priming via a double change, then a double change back raises err.
      set_ab(1'b1, 1'b1, 10);
      chk("prime_no_err", n_err, 0);
      set_ab(1'b0, 1'b0, 10);
      e_err++;
      chk("double_change_err", n_err, e_err);
      chk("double_change_value", int'(value), 0);
      chk("double_change_no_inc", n_inc, 0);

      // One clean clockwise detent, latency from the final raw edge.
      set_ab(1'b1, 1'b0, 10);
      set_ab(1'b1, 1'b1, 10);
      set_ab(1'b0, 1'b1, 10);
      set_ab(1'b0, 1'b0, 6);
      chk("cw_edge6_value", int'(value), 0);
      chk("cw_edge6_inc", int'(inc), 0);
      @(negedge clk);
      chk("cw_edge7_value", int'(value), 1);
      chk("cw_edge7_inc", int'(inc), 1);
      @(negedge clk);
      chk("cw_edge8_inc", int'(inc), 0);
      repeat (8) @(negedge clk);
      e_inc++;
      e_val = 1;
      chk("cw_inc_count", n_inc, e_inc);
      chk("acc_clear_after_err", n_err, e_err);

      ccw_detent(10);
      e_val = dn(e_val); e_dec++;
      chk("ccw1_value", int'(value), e_val);
      ccw_detent(10);
      e_val = dn(e_val); e_dec++;
      chk("ccw2_value", int'(value), e_val);
      ccw_detent(10);
      e_val = dn(e_val); e_dec++;
      chk("ccw3_value", int'(value), e_val);
      chk("ccw_dec_count", n_dec, e_dec);

      while (e_val != 254) begin
         cw_detent(8);
         e_val = up(e_val);
         e_inc++;
      end
      chk("climb_value", int'(value), 254);
      chk("climb_inc_count", n_inc, e_inc);

      cw_detent(10);
      e_val = up(e_val); e_inc++;
      chk("top1_value", int'(value), e_val);
      cw_detent(10);
      e_val = up(e_val); e_inc++;
      chk("top2_value", int'(value), e_val);
      chk("top_inc_count", n_inc, e_inc);

      // Channel A bounces with 2-cycle pulses before settling.
      for (int i = 0; i < 3; i++) begin
         set_ab(1'b1, 1'b0, 2);
         set_ab(1'b0, 1'b0, 2);
      end
      set_ab(1'b1, 1'b0, 10);
      chk("bounce_no_err", n_err, e_err);
      chk("bounce_value_hold", int'(value), e_val);
      set_ab(1'b1, 1'b1, 10);
      set_ab(1'b0, 1'b1, 10);
      set_ab(1'b0, 1'b0, 10);
      e_val = up(e_val); e_inc++;
      chk("bounce_value", int'(value), e_val);
      chk("bounce_inc_count", n_inc, e_inc);
      chk("bounce_err_count", n_err, e_err);

      // Short pulse on B is filtered out entirely.
      set_ab(1'b0, 1'b1, 3);
      set_ab(1'b0, 1'b0, 12);
      chk("glitch_value", int'(value), e_val);
      chk("glitch_inc", n_inc, e_inc);
      chk("glitch_dec", n_dec, e_dec);
      chk("glitch_err", n_err, e_err);

      // Reset after three clockwise quarter-steps.
      set_ab(1'b1, 1'b0, 10);
      set_ab(1'b1, 1'b1, 10);
      set_ab(1'b0, 1'b1, 10);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      e_val = 0;
      chk("midreset_value", int'(value), 0);
      chk("midreset_inc", int'(inc), 0);
      repeat (10) @(negedge clk);
      set_ab(1'b0, 1'b0, 10);
      chk("midreset_step_value", int'(value), 0);
      chk("midreset_step_inc", n_inc, e_inc);
      cw_detent(10);
      e_inc++;
      chk("post_reset_detent_value", int'(value), 1);
      chk("post_reset_inc_count", n_inc, e_inc);

      chk("pulse_overlap", n_overlap, 0);
      chk("pulse_wide", n_wide, 0);
      chk("final_dec_count", n_dec, e_dec);
      chk("final_err_count", n_err, e_err);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/quad_encoder_counter.md
QUAD_ENCODER_COUNTER -- requirements
Module: quad_encoder_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: width of the value counter.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, legal range 1..255: consecutive stable cycles required before a filtered input updates.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port enc_a  input  1  raw quadrature channel A, asynchronous to clk.
REQ-006 The block SHALL have port enc_b  input  1  raw quadrature channel B, asynchronous to clk.
REQ-007 The block SHALL have port value  output  WIDTH  current detent count, feeding the downstream PWM duty input.
REQ-008 The block SHALL have port inc  output  1  one-cycle pulse on each clockwise detent.
REQ-009 The block SHALL have port dec  output  1  one-cycle pulse on each counter-clockwise detent.
REQ-010 The block SHALL have port err  output  1  one-cycle pulse on an illegal quadrature transition.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchroniser before any other logic.
REQ-012 Each channel SHALL have an independent debounce counter: the filtered bit takes the synchronised value only after that value has differed from the filtered bit for DEBOUNCE_CYCLES consecutive cycles; any return to the filtered value clears the counter.
REQ-013 The decoder SHALL compare the filtered state {A,B} with the previous filtered state every cycle; a change of exactly one bit is a quarter-step.
REQ-014 Clockwise quarter-steps SHALL be 00->10->11->01->00; counter-clockwise is the reverse sequence.
REQ-015 Quarter-steps SHALL accumulate in a signed accumulator (range -3..+3): +1 clockwise, -1 counter-clockwise.
REQ-016 When the accumulator would reach +4, value SHALL increment by 1, inc SHALL pulse, and the accumulator SHALL clear to 0; when it would reach -4, the same applies with decrement and dec.
REQ-017 A change of both filtered bits in one cycle SHALL pulse err, leave value and the accumulator unchanged, and update the previous state.
REQ-018 inc, dec and err SHALL be mutually exclusive, and each SHALL be high for exactly one cycle per event.
REQ-019 value and inc/dec SHALL update exactly DEBOUNCE_CYCLES+3 rising edges after a clean, bounce-free raw edge that completes a detent.
REQ-020 Without saturation, value SHALL wrap: 2^WIDTH-1 + 1 -> 0 and 0 - 1 -> 2^WIDTH-1.
REQ-021 A raw pulse shorter than DEBOUNCE_CYCLES cycles after synchronisation SHALL cause no change to any output.

Reset
REQ-022 While reset is high at a rising edge, the block SHALL clear value to 0, inc/dec/err to 0, the accumulator to 0, the synchronisers to 0, the debounce counters to 0, and the filtered state to 00, and SHALL clear a primed flag.
REQ-023 While primed is clear, the first filtered state change after reset SHALL be loaded as the previous state without counting and without err; the same cycle sets primed.
REQ-024 Reset asserted mid-detent SHALL discard the partial accumulation; no inc or dec pulse SHALL occur on that cycle or the cycle after.

Configuration
REQ-025 With macro QUAD_ENCODER_SATURATE_EN defined, value SHALL clamp at 0 and at 2^WIDTH-1 instead of wrapping; inc and dec SHALL still pulse on every detent, even while clamped.
REQ-026 With QUAD_ENCODER_SATURATE_EN undefined, value SHALL wrap as in REQ-020.

Verification
REQ-027 After priming, with WIDTH=8 and DEBOUNCE_CYCLES=4, one clean clockwise detent (AB 00->10->11->01->00, each step held 10 cycles) -> value 0->1 and a single inc pulse, 7 edges after the final raw edge.
REQ-028 Two counter-clockwise detents from value 0 with the macro undefined -> value 255 then 254 and two dec pulses; with the macro defined -> value stays 0 and two dec pulses still occur.
REQ-029 enc_a bounces 3 times with 2-cycle pulses before settling -> exactly one filtered transition; no err pulse; the count is correct.
REQ-030 Both filtered bits forced to change from 00 to 11 in the same cycle -> one err pulse; value and accumulator unchanged.
REQ-031 Reset asserted after 3 clockwise quarter-steps, then one more quarter-step -> value 0, no inc pulse; a subsequent full detent yields value 1.
REQ-032 Clockwise detents from 254 -> value 255 then 0 with the macro undefined, or 255 then 255 with it defined; inc pulses on both detents in each case.
